pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It decides each cycle whether the PC and the IF/ID register hold (stop_sel) and whether ID/EX takes a bubble. It resolves register read-after-write hazards with Tuse/Tnew comparison. It also sequences the multi-cycle mult/div unit, serialising HI/LO users behind it, and keeps a stall-cycle performance counter.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle (>=1)
DIV_CYCLES, 10, busy cycles for div/divu after the start cycle (>=1)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high
D_rs_addr  input  5  rs index of instruction in D
D_rt_addr  input  5  rt index of instruction in D
D_rs_tuse  input  2  cycles until D needs rs (0..2); 3 = not used
D_rt_tuse  input  2  cycles until D needs rt; 3 = not used
D_is_md  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_wr_addr  input  5  destination register of instruction in E (0 = none)
E_tnew  input  2  cycles until E result is forwardable
M_wr_addr  input  5  destination register of instruction in M
M_tnew  input  2  cycles until M result is forwardable
E_md_start  input  1  mult/div in E issues to the MDU this cycle
E_md_op  input  1  0 = mult/multu, 1 = div/divu
stop_sel  output  1  1 = PC and IF/ID hold their value
idex_flush  output  1  1 = ID/EX loads a bubble (nop, PC 0x3000) next edge
md_busy  output  1  MDU is computing
md_done  output  1  last busy cycle, one-cycle pulse
stall_cnt  output  32  number of cycles with stop_sel=1 since reset

Behaviour:
- State: IDLE, BUSY; down-counter cnt[3:0] or wider, sized to hold max(MULT_CYCLES, DIV_CYCLES).
- Reset (synchronous, active-high): state=IDLE, cnt=0, stall_cnt=0. Outputs are then md_busy=0, md_done=0. stop_sel and idex_flush follow the combinational rules below with busy=0.
- IDLE with E_md_start=1: at the next edge go BUSY, cnt = E_md_op ? DIV_CYCLES : MULT_CYCLES.
- BUSY: cnt decrements each edge. When cnt==1, md_done=1 and the next edge returns to IDLE.
- md_busy = (state==BUSY). It is high for exactly N cycles after the start cycle.
- E_md_start while BUSY is ignored. It cannot occur legally, because D is stalled.
- Register hazards, rs (rt is identical):
  - stall_rs_E = D_rs_addr!=0 & D_rs_addr==E_wr_addr & D_rs_tuse < E_tnew
  - stall_rs_M = D_rs_addr!=0 & D_rs_addr==M_wr_addr & D_rs_tuse < M_tnew
  - tuse=3 never stalls.
- MD stall = D_is_md & (md_busy | E_md_start).
- stop_sel = any register stall | MD stall. This is purely combinational from inputs and state, so it takes effect in the same cycle.
- idex_flush = stop_sel. A stalled D never advances a duplicate into E.
- md_done does not by itself release a stall. The stall releases in the cycle after md_done, when md_busy=0.
- stall_cnt increments at each edge where stop_sel=1. It wraps at 2^32-1 → 0. Reset takes priority.
- Reset mid-BUSY: abort immediately; md_busy=0 in the cycle after the reset edge.
- Addr 0 never stalls, even if E_tnew>0.

Test Plan:
- E_wr_addr=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=1 → stop_sel=1, idex_flush=1. Change tuse to 2 → stop_sel=0.
- M_wr_addr=9, M_tnew=1, D_rt_addr=9, D_rt_tuse=0 → stall. D_rt_addr=0 with E/M addr=0, tnew=2 → no stall.
- E_md_start=1, E_md_op=0 at cycle 0 → md_busy high cycles 1-5, md_done only cycle 5, IDLE at cycle 6. D_is_md=1 throughout → stop_sel high cycles 0-5, low at 6.
- E_md_op=1 start → md_busy for 10 cycles. A non-MD D instruction with no register hazard → stop_sel=0 throughout.
- Assert reset in busy cycle 3 of a div → md_busy=0, stall_cnt=0 next cycle. A subsequent start counts a full 10 cycles.
- Hold a hazard 7 cycles → stall_cnt=7. Preload is not possible, so force wrap via a long run or a bench-only force: 0xFFFFFFFF +1 → 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs from D/E/M stages and stall/MDU status outputs
interface pipe_stall_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_is_md;
  logic [4:0]  E_wr_addr;
  logic [1:0]  E_tnew;
  logic [4:0]  M_wr_addr;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_op;
  logic        stop_sel;
  logic        idex_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;
  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    output E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_op,
    input  stop_sel, idex_flush, md_busy, md_done, stall_cnt
  );
  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    input  E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_op,
    output stop_sel, idex_flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: Tuse/Tnew hazard stall, mult/div sequencing and stall-cycle counter
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   stall_q;
  logic          stall_rs, stall_rt, stall_md, busy;
  // tuse=3 can never be below a 2-bit tnew, so "not used" falls out of the compare
  assign stall_rs = bus.D_rs_addr != 5'd0 &&
                    ((bus.D_rs_addr == bus.E_wr_addr && bus.D_rs_tuse < bus.E_tnew) ||
                     (bus.D_rs_addr == bus.M_wr_addr && bus.D_rs_tuse < bus.M_tnew));
  assign stall_rt = bus.D_rt_addr != 5'd0 &&
                    ((bus.D_rt_addr == bus.E_wr_addr && bus.D_rt_tuse < bus.E_tnew) ||
                     (bus.D_rt_addr == bus.M_wr_addr && bus.D_rt_tuse < bus.M_tnew));
  assign busy           = state == BUSY;
  assign stall_md       = bus.D_is_md && (busy || bus.E_md_start);
  assign bus.stop_sel   = stall_rs || stall_rt || stall_md;
  assign bus.idex_flush = bus.stop_sel;
  assign bus.md_busy    = busy;
  assign bus.md_done    = busy && cnt == CW'(1);
  assign bus.stall_cnt  = stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(bus.stop_sel);
      if (state == IDLE) begin
        if (bus.E_md_start) begin
          state <= BUSY;
          cnt   <= bus.E_md_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of hazard stalls, MDU sequencing and stall counter
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  pipe_stall_ctrl_if bus ();
  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_stop"}, {31'd0, bus.stop_sel}, {31'd0, exp});
    chk({tag, "_flush"}, {31'd0, bus.idex_flush}, {31'd0, exp});
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_in;
    bus.D_rs_addr = 0; bus.D_rt_addr = 0; bus.D_rs_tuse = 3; bus.D_rt_tuse = 3;
    bus.D_is_md = 0; bus.E_wr_addr = 0; bus.E_tnew = 0; bus.M_wr_addr = 0;
    bus.M_tnew = 0; bus.E_md_start = 0; bus.E_md_op = 0;
  endtask
  initial begin
    clear_in();
    tick(); tick();
    #1;
    chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.md_done}, 32'd0);
    chk("rst_cnt", bus.stall_cnt, 32'd0);
    chk_stall("rst", 1'b0);
    reset = 1'b0;
    tick();
    bus.E_wr_addr = 8; bus.E_tnew = 2; bus.D_rs_addr = 8; bus.D_rs_tuse = 1; #1;
    chk_stall("rs_e_t1", 1'b1);
    bus.D_rs_tuse = 2; #1;
    chk_stall("rs_e_t2", 1'b0);
    bus.D_rs_tuse = 3; #1;
    chk_stall("rs_e_t3", 1'b0);
    clear_in();
    bus.M_wr_addr = 9; bus.M_tnew = 1; bus.D_rt_addr = 9; bus.D_rt_tuse = 0; #1;
    chk_stall("rt_m", 1'b1);
    clear_in();
    bus.D_rt_tuse = 0; bus.E_tnew = 2; bus.M_tnew = 2; #1;
    chk_stall("addr0", 1'b0);
    clear_in();
    bus.E_wr_addr = 4; bus.E_tnew = 1; bus.D_rt_addr = 4; bus.D_rt_tuse = 0; #1;
    chk_stall("rt_e", 1'b1);
    clear_in();
    bus.M_wr_addr = 6; bus.M_tnew = 1; bus.D_rs_addr = 6; bus.D_rs_tuse = 1; #1;
    chk_stall("rs_m_eq", 1'b0);
    clear_in();
    reset = 1'b1; tick(); reset = 1'b0;
    // mult start at cycle 0 with an MD instruction waiting in D
    bus.E_md_start = 1; bus.E_md_op = 0; bus.D_is_md = 1; #1;
    chk("mul_c0_busy", {31'd0, bus.md_busy}, 32'd0);
    chk_stall("mul_c0", 1'b1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.E_md_start = (i == 2); bus.E_md_op = 1; #1;
      chk($sformatf("mul_c%0d_busy", i), {31'd0, bus.md_busy}, 32'd1);
      chk($sformatf("mul_c%0d_done", i), {31'd0, bus.md_done}, {31'd0, i == 5});
      chk($sformatf("mul_c%0d_stop", i), {31'd0, bus.stop_sel}, 32'd1);
      tick();
    end
    #1;
    chk("mul_c6_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("mul_c6_done", {31'd0, bus.md_done}, 32'd0);
    chk_stall("mul_c6", 1'b0);
    chk("mul_cnt", bus.stall_cnt, 32'd6);
    clear_in();
    bus.E_md_start = 1; bus.E_md_op = 1; #1;
    chk_stall("div_c0", 1'b0);
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("div_c%0d_busy", i), {31'd0, bus.md_busy}, 32'd1);
      chk($sformatf("div_c%0d_done", i), {31'd0, bus.md_done}, {31'd0, i == 10});
      chk($sformatf("div_c%0d_stop", i), {31'd0, bus.stop_sel}, 32'd0);
      tick();
    end
    #1;
    chk("div_c11_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("div_cnt", bus.stall_cnt, 32'd6);
    bus.E_md_start = 1; bus.E_md_op = 1;
    tick();
    bus.E_md_start = 0;
    tick(); tick();
    #1;
    chk("abort_c3_busy", {31'd0, bus.md_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("abort_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("abort_cnt", bus.stall_cnt, 32'd0);
    bus.E_md_start = 1; bus.E_md_op = 1;
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("redo_c%0d_busy", i), {31'd0, bus.md_busy}, 32'd1);
      chk($sformatf("redo_c%0d_done", i), {31'd0, bus.md_done}, {31'd0, i == 10});
      tick();
    end
    #1;
    chk("redo_end_busy", {31'd0, bus.md_busy}, 32'd0);
    bus.E_wr_addr = 8; bus.E_tnew = 2; bus.D_rs_addr = 8; bus.D_rs_tuse = 0;
    for (int i = 0; i < 7; i++) tick();
    clear_in(); #1;
    chk("hold7_cnt", bus.stall_cnt, 32'd7);
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    #1;
    chk("wrap_pre", bus.stall_cnt, 32'hFFFF_FFFF);
    bus.E_wr_addr = 8; bus.E_tnew = 2; bus.D_rs_addr = 8; bus.D_rs_tuse = 0;
    tick();
    clear_in(); #1;
    chk("wrap_post", bus.stall_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
